// File: rtl/tile_video_pkg.sv
// rtl/tile_video_pkg.sv - shared constants, helpers and fetch encodings for tile_video_gen
// Purpose: Blockade default timing, counter width, ceil-log2 helper, fetch pipeline states.
package tile_video_pkg;

  // Blockade default raster: 330 x 262 total, 256 x 224 visible
  localparam int DEF_H_TOTAL  = 330;
  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_HS_START = 272;
  localparam int DEF_HS_END   = 301;
  localparam int DEF_V_TOTAL  = 262;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_VS_START = 254;

  // Width of the raw hcnt/vcnt counters
  localparam int CNT_W = 9;

  // State of the per-tile fetch pipeline: what the next ce has to do
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,  // nothing pending, may start an address cycle
    FETCH_CODE = 2'd1,  // VRAM data valid: issue GFX PROM address
    FETCH_LOAD = 2'd2   // PROM data valid: load pixel row
  } fetch_st_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tile_video_timing.sv
// rtl/tile_video_timing.sv - raster counters with registered sync/blank decode
// Ports:
//   clk, reset_n, ce       clock, async active-low reset, pixel clock enable
//   hcnt, vcnt             raw counters (0..H_TOTAL-1, 0..V_TOTAL-1)
//   hsync, vsync           active-high syncs, one ce behind the counters
//   hblank, vblank         active-high blanks, one ce behind the counters
//   phase                  position inside the current tile (hcnt low bits)
//   line_end               hcnt is at its last value of the line
module tile_video_timing import tile_video_pkg::*; #(
  parameter int H_TOTAL   = DEF_H_TOTAL,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int HS_START  = DEF_HS_START,
  parameter int HS_END    = DEF_HS_END,
  parameter int V_TOTAL   = DEF_V_TOTAL,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int VS_START  = DEF_VS_START,
  parameter int TILE_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  output logic [CNT_W-1:0]     hcnt,
  output logic [CNT_W-1:0]     vcnt,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 hblank,
  output logic                 vblank,
  output logic [TILE_LOG2-1:0] phase,
  output logic                 line_end
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_S   = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_E   = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0] VS_S   = CNT_W'(VS_START);

  assign line_end = (hcnt == H_LAST);
  assign phase    = hcnt[TILE_LOG2-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt   <= '0;
      vcnt   <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
    end else if (ce) begin
      hcnt <= line_end ? '0 : hcnt + 1'b1;
      if (line_end) begin
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end
      // decoded from the pre-increment counters so they line up with pix
      hsync  <= (hcnt >= HS_S) && (hcnt < HS_E);
      vsync  <= (vcnt >= VS_S);
      hblank <= (hcnt >= H_ACT);
      vblank <= (vcnt >= V_ACT);
    end
  end

endmodule

// File: rtl/tile_video_gen.sv
// rtl/tile_video_gen.sv - tilemap video generator: timing, tile fetch, pixel row, CPU VRAM arbitration
// Ports:
//   clk, reset_n, ce        clock, async active-low reset, pixel clock enable
//   flip                    flip-screen request, taken at frame start
//   vram_addr / vram_data   tilemap address {row,col}; tile code returned 1 clk later
//   gfx_addr / gfx_data     PROM address {code,tile row}; plane-major pixel row 1 clk later
//   cpu_vram_req/cpu_ready  CPU VRAM access request and registered READY
//   pix                     colour index, 0 while blanked
//   hsync, vsync, hblank, vblank, hcnt, vcnt   raster outputs
module tile_video_gen import tile_video_pkg::*; #(
  parameter int H_TOTAL       = DEF_H_TOTAL,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int HS_START      = DEF_HS_START,
  parameter int HS_END        = DEF_HS_END,
  parameter int V_TOTAL       = DEF_V_TOTAL,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int VS_START      = DEF_VS_START,
  parameter int TILE_LOG2     = 3,
  parameter int MAP_COLS_LOG2 = 5,
  parameter int CODE_W        = 5,
  parameter int BPP           = 1,
  parameter int HB_ACCESS     = 0
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  ce,
  input  logic                                                  flip,
  output logic [MAP_COLS_LOG2+clog2(V_ACTIVE)-TILE_LOG2-1:0]     vram_addr,
  input  logic [7:0]                                            vram_data,
  output logic [CODE_W+TILE_LOG2-1:0]                           gfx_addr,
  input  logic [BPP*(1<<TILE_LOG2)-1:0]                         gfx_data,
  input  logic                                                  cpu_vram_req,
  output logic                                                  cpu_ready,
  output logic [BPP-1:0]                                        pix,
  output logic                                                  hsync,
  output logic                                                  vsync,
  output logic                                                  hblank,
  output logic                                                  vblank,
  output logic [CNT_W-1:0]                                      hcnt,
  output logic [CNT_W-1:0]                                      vcnt
);

  localparam int N     = 1 << TILE_LOG2;
  localparam int ROW_W = clog2(V_ACTIVE) - TILE_LOG2;
  localparam int COL_W = MAP_COLS_LOG2;

  localparam logic [CNT_W-1:0]     PRE_H   = CNT_W'(H_TOTAL - 3);
  // last hcnt a regular fetch may start at without overlapping the tile-0 prefetch
  localparam logic [CNT_W-1:0]     REG_MAX = CNT_W'(H_TOTAL - 6);
  localparam logic [CNT_W-1:0]     V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]     H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]     V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [TILE_LOG2-1:0] P_ADDR  = TILE_LOG2'(N - 3);
  localparam logic [TILE_LOG2-1:0] P_CODE  = TILE_LOG2'(N - 2);
  // flipped picture is mirrored inside the visible area, not the whole map
  localparam logic [COL_W-1:0]     COL_MIR = COL_W'(H_ACTIVE / N - 1);
  localparam logic [ROW_W-1:0]     ROW_MIR = ROW_W'(V_ACTIVE / N - 1);

  logic [TILE_LOG2-1:0] phase;
  logic                 line_end;

  tile_video_timing #(
    .H_TOTAL  (H_TOTAL),
    .H_ACTIVE (H_ACTIVE),
    .HS_START (HS_START),
    .HS_END   (HS_END),
    .V_TOTAL  (V_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .VS_START (VS_START),
    .TILE_LOG2(TILE_LOG2)
  ) u_timing (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .hsync   (hsync),
    .vsync   (vsync),
    .hblank  (hblank),
    .vblank  (vblank),
    .phase   (phase),
    .line_end(line_end)
  );

  fetch_st_t fetch_st, fetch_nx;
  logic      start_pre, start_reg, start_fetch;
  logic      do_addr, do_code, do_load;

  logic [CNT_W-1:0]     next_line, fetch_line, tile_next;
  logic                 fetch_flip;
  logic [COL_W-1:0]     col_raw, col_sel;
  logic [ROW_W-1:0]     row_raw, row_sel;
  logic [TILE_LOG2-1:0] trow_raw, trow_sel;

  logic [TILE_LOG2-1:0] f_trow;
  logic                 f_flip;
  logic [BPP*N-1:0]     tile_row;
  logic                 tile_flip;
  logic [TILE_LOG2-1:0] pix_idx;
  logic [BPP-1:0]       pix_nx;
  logic                 pix_on;
  logic                 flip_q;
  logic                 line_ok;
  logic                 unused_vram;

  assign unused_vram = ^vram_data;

  // tile 0 of the next line is prefetched at the end of the current one
  assign start_pre   = (hcnt == PRE_H);
  assign start_reg   = (phase == P_ADDR) && (hcnt <= REG_MAX);
  assign start_fetch = start_pre || start_reg;

  assign next_line  = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
  assign fetch_line = start_pre ? next_line : vcnt;
  assign tile_next  = (hcnt >> TILE_LOG2) + 1'b1;

  // the line-0 prefetch happens before flip_q samples flip, so it looks at flip directly
  assign fetch_flip = (start_pre && (vcnt == V_LAST)) ? flip : flip_q;

  assign col_raw  = start_pre ? '0 : COL_W'(tile_next);
  assign row_raw  = ROW_W'(fetch_line >> TILE_LOG2);
  assign trow_raw = fetch_line[TILE_LOG2-1:0];
  assign col_sel  = fetch_flip ? COL_MIR - col_raw : col_raw;
  assign row_sel  = fetch_flip ? ROW_MIR - row_raw : row_raw;
  assign trow_sel = fetch_flip ? ~trow_raw : trow_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_st <= FETCH_IDLE;
    else          fetch_st <= fetch_nx;
  end

  always_comb begin
    fetch_nx = fetch_st;
    do_addr  = 1'b0;
    do_code  = 1'b0;
    do_load  = 1'b0;
    if (ce) begin
      case (fetch_st)
        FETCH_CODE: begin
          do_code  = 1'b1;
          fetch_nx = FETCH_LOAD;
        end
        FETCH_LOAD: begin
          do_load  = 1'b1;
          fetch_nx = FETCH_IDLE;
        end
        default: begin
          if (start_fetch) begin
            do_addr  = 1'b1;
            fetch_nx = FETCH_CODE;
          end
        end
      endcase
    end
  end

  // each tile carries its own flip so the first tile of a frame is consistent
  assign pix_idx = tile_flip ? ~phase : phase;
  assign pix_on  = line_ok && (hcnt < H_ACT) && (vcnt < V_ACT);

  always_comb begin
    pix_nx = '0;
    for (int b = 0; b < BPP; b++) begin
      pix_nx[b] = tile_row[b*N + int'(pix_idx)];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_addr <= '0;
      gfx_addr  <= '0;
      f_trow    <= '0;
      f_flip    <= 1'b0;
      tile_row  <= '0;
      tile_flip <= 1'b0;
      pix       <= '0;
      flip_q    <= 1'b0;
      line_ok   <= 1'b0;
      cpu_ready <= 1'b0;
    end else begin
      cpu_ready <= !cpu_vram_req || vblank ||
                   ((HB_ACCESS != 0) && hblank && (phase != P_ADDR) && (phase != P_CODE));
      if (ce) begin
        if ((hcnt == '0) && (vcnt == '0)) flip_q <= flip;
        // the line after reset had no tile-0 prefetch
        if (line_end) line_ok <= 1'b1;
        if (do_addr) begin
          vram_addr <= {row_sel, col_sel};
          f_trow    <= trow_sel;
          f_flip    <= fetch_flip;
        end
        if (do_code) gfx_addr <= {vram_data[CODE_W-1:0], f_trow};
        // pix below still reads the old row on the load ce (last pixel of the tile)
        if (do_load) begin
          tile_row  <= gfx_data;
          tile_flip <= f_flip;
        end
        pix <= pix_on ? pix_nx : '0;
      end
    end
  end

endmodule
